// File: rtl/button_pkg.sv
// Shared defaults and helpers for the button conditioner.
package button_pkg;

    localparam int SAMPLE_CNT_MAX_DEFAULT = 62500;
    localparam int PULSE_CNT_MAX_DEFAULT  = 200;

    // Counter width able to hold 0..max_val-1, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/synchronizer.sv
// Two-flop synchronizer bringing asynchronous levels into the clk domain.
module synchronizer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture; meta_r may go metastable, sync_r is the settled copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/button_conditioner.sv
// Debounce, press-strobe and optional toggle for WIDTH buttons.
// Define BUTTON_TOGGLE_EN to build the per-channel toggle register.
module button_conditioner
    import button_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int SAMPLE_CNT_MAX = SAMPLE_CNT_MAX_DEFAULT,
    parameter int PULSE_CNT_MAX  = PULSE_CNT_MAX_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] buttons,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] pulse,
    output logic [WIDTH-1:0] toggle
);

    localparam int SW = cnt_width(SAMPLE_CNT_MAX);
    localparam int CW = cnt_width(PULSE_CNT_MAX + 1);
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CNT_MAX - 1);
    localparam logic [CW-1:0] PULSE_FULL  = CW'(PULSE_CNT_MAX);

    logic [WIDTH-1:0] sync_s;
    logic             sample_tick_s;
    logic [SW-1:0]    sample_cnt_r;
    logic [CW-1:0]    sat_cnt_r [WIDTH];
    logic [WIDTH-1:0] level_s;
    logic [WIDTH-1:0] level_d_r;
    logic [WIDTH-1:0] pulse_r;

    synchronizer #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (buttons),
        .q     (sync_s)
    );

    assign sample_tick_s = (sample_cnt_r == SAMPLE_LAST);

    // Shared free-running sample divider, wraps on the tick cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt_r <= {SW{1'b0}};
        end else if (sample_tick_s) begin
            sample_cnt_r <= {SW{1'b0}};
        end else begin
            sample_cnt_r <= sample_cnt_r + SW'(1);
        end
    end

    // Per-channel saturating high-sample counters; any low sample restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                sat_cnt_r[i] <= {CW{1'b0}};
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sample_tick_s) begin
                    if (!sync_s[i]) begin
                        sat_cnt_r[i] <= {CW{1'b0}};
                    end else if (sat_cnt_r[i] != PULSE_FULL) begin
                        sat_cnt_r[i] <= sat_cnt_r[i] + CW'(1);
                    end else begin
                        sat_cnt_r[i] <= sat_cnt_r[i];
                    end
                end else begin
                    sat_cnt_r[i] <= sat_cnt_r[i];
                end
            end
        end
    end

    // Debounced level is a direct compare on the saturated count.
    always_comb begin
        level_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            level_s[i] = (sat_cnt_r[i] == PULSE_FULL);
        end
    end

    // Rising-edge detect of the debounced level gives a one-cycle strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d_r <= {WIDTH{1'b0}};
            pulse_r   <= {WIDTH{1'b0}};
        end else begin
            level_d_r <= level_s;
            pulse_r   <= level_s & ~level_d_r;
        end
    end

    assign level = level_s;
    assign pulse = pulse_r;

`ifdef BUTTON_TOGGLE_EN
    logic [WIDTH-1:0] toggle_r;

    // Flip each channel's state on its press strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_r <= {WIDTH{1'b0}};
        end else begin
            toggle_r <= toggle_r ^ pulse_r;
        end
    end

    assign toggle = toggle_r;
`else
    assign toggle = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner (WIDTH=4, sample 4, pulse 3).
module tb_button_conditioner;

    localparam int W = 4;
`ifdef BUTTON_TOGGLE_EN
    localparam bit TOG = 1'b1;
`else
    localparam bit TOG = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic [W-1:0] buttons;
    logic [W-1:0] level;
    logic [W-1:0] pulse;
    logic [W-1:0] toggle;

    int n_tests;
    int n_fail;
    int pulse_cnt [W];
    logic [W-1:0] bad_pulse;
    logic [W-1:0] level_or;
    logic [W-1:0] out_or;
    logic [W-1:0] prev_pulse;

    button_conditioner #(
        .WIDTH          (W),
        .SAMPLE_CNT_MAX (4),
        .PULSE_CNT_MAX  (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .buttons (buttons),
        .level   (level),
        .pulse   (pulse),
        .toggle  (toggle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < W; i++) pulse_cnt[i] = 0;
        bad_pulse  = '0;
        level_or   = '0;
        out_or     = '0;
        prev_pulse = pulse;
    endtask

    // Advance to the next falling edge and accumulate output statistics.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < W; i++) pulse_cnt[i] += int'(pulse[i]);
        bad_pulse  = bad_pulse | (pulse & (~level | prev_pulse));
        level_or   = level_or | level;
        out_or     = out_or | level | pulse | toggle;
        prev_pulse = pulse;
    endtask

    initial begin
        int lat;
        logic [W-1:0] first_p;
        bit found;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        buttons = '0;
        clear_stats();
        repeat (3) step();
        check_eq("reset_outputs", {level, pulse, toggle}, 12'h000);
        rst_n = 1'b1;

        // Idle for 100 cycles: nothing may assert.
        clear_stats();
        repeat (100) step();
        check_eq("idle_outputs", out_or, 4'h0);

        // Single press on channel 0.
        clear_stats();
        buttons = 4'b0001;
        lat = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (level[0] && lat == 0) begin
                lat = i;
                break;
            end
        end
        check_eq("ch0_level_latency_ok", (lat >= 10 && lat <= 15), 1);
        check_eq("ch0_pulse_not_with_level", pulse[0], 1'b0);
        step();
        check_eq("ch0_pulse_next_cycle", pulse, 4'b0001);
        step();
        check_eq("ch0_pulse_one_cycle", pulse[0], 1'b0);
        repeat (24) step();
        check_eq("ch0_pulse_count", pulse_cnt[0], 1);
        check_eq("ch0_other_levels", level_or[3:1], 3'b000);
        check_eq("ch0_level_held", level, 4'b0001);
        check_eq("ch0_toggle", toggle, {3'b000, TOG});
        buttons = 4'b0000;
        repeat (20) step();
        check_eq("ch0_level_fell", level, 4'b0000);

        // Short glitch on channel 1 must be rejected.
        clear_stats();
        buttons = 4'b0010;
        repeat (6) step();
        buttons = 4'b0000;
        repeat (30) step();
        check_eq("ch1_glitch_level", level_or[1], 1'b0);
        check_eq("ch1_glitch_pulse", pulse_cnt[1], 0);
        check_eq("ch1_sat_cleared", dut.sat_cnt_r[1], 0);

        // Two full press/release cycles on channel 2.
        clear_stats();
        for (int r = 0; r < 2; r++) begin
            buttons = 4'b0100;
            repeat (40) step();
            if (r == 0) check_eq("ch2_toggle_mid", toggle[2], TOG);
            buttons = 4'b0000;
            repeat (40) step();
        end
        check_eq("ch2_pulse_count", pulse_cnt[2], 2);
        check_eq("ch2_other_pulses", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[3], 0);
        check_eq("ch2_toggle_end", toggle[2], 1'b0);
        check_eq("bad_pulse_so_far", bad_pulse, 4'h0);

        // All four channels pressed together.
        clear_stats();
        buttons = 4'b1111;
        first_p = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (pulse != 4'b0000) begin
                first_p = pulse;
                break;
            end
        end
        check_eq("all_simultaneous_pulse", first_p, 4'b1111);
        step();
        check_eq("all_toggle", toggle, {TOG, TOG, TOG, 1'b0});

        // Reset mid-count with channel 3 held.
        buttons = 4'b1000;
        repeat (20) step();
        check_eq("ch3_level_before_reset", level, 4'b1000);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (dut.sample_cnt_r == 2) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("sample_cnt_at_2_found", found, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_clear", {level, pulse, toggle}, 12'h000);
        check_eq("async_reset_sat3", dut.sat_cnt_r[3], 0);
        repeat (3) step();
        rst_n = 1'b1;
        clear_stats();
        lat = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (level[3] && lat == 0) begin
                lat = i;
                break;
            end
        end
        check_eq("ch3_post_reset_level_latency", lat, 12);
        step();
        check_eq("ch3_post_reset_pulse", pulse, 4'b1000);
        repeat (20) step();
        check_eq("ch3_post_reset_pulse_count", pulse_cnt[3], 1);
        check_eq("ch3_post_reset_toggle", toggle, {TOG, 3'b000});
        check_eq("bad_pulse_final", bad_pulse, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001: Parameter WIDTH, default 4: number of independent button channels.
REQ-002: Parameter SAMPLE_CNT_MAX, default 62500: clock cycles per sample tick, 0.5 ms at 125 MHz.
REQ-003: Parameter PULSE_CNT_MAX, default 200: consecutive high sample ticks required to declare a press.
REQ-004: clk  input  1  single system clock; all state on its rising edge.
REQ-005: rst_n  input  1  reset, asynchronous, active-low.
REQ-006: buttons  input  WIDTH  raw asynchronous button levels, active-high.
REQ-007: level  output  WIDTH  debounced button level per channel.
REQ-008: pulse  output  WIDTH  one-cycle press strobe per channel, suitable as a counter clock enable.
REQ-009: toggle  output  WIDTH  per-channel state flipped on each press.

Function
REQ-010: Each buttons bit SHALL pass through a 2-flop synchronizer; sync output lags the input by 2 clk edges.
REQ-011: One shared sample counter SHALL count 0..SAMPLE_CNT_MAX-1 and wrap to 0; sample_tick is high for the single cycle the counter equals SAMPLE_CNT_MAX-1.
REQ-012: Sample counter width SHALL be $clog2(SAMPLE_CNT_MAX); no wrap glitch or skipped tick at the boundary.
REQ-013: Per channel, a saturating counter of width $clog2(PULSE_CNT_MAX+1) SHALL, on sample_tick: increment when the sync bit is 1 and count < PULSE_CNT_MAX; hold at PULSE_CNT_MAX when saturated; clear to 0 when the sync bit is 0.
REQ-014: Without sample_tick, the saturating counter SHALL hold.
REQ-015: level[i] SHALL be 1 exactly when channel i's saturating counter equals PULSE_CNT_MAX (compare on registered state, no extra delay).
REQ-016: pulse[i] SHALL be registered: high for exactly one cycle, the cycle after level[i] goes 0->1; never high on level falling or while level is held.
REQ-017: A held button SHALL produce one pulse only; a new pulse requires level to fall and re-saturate.
REQ-018: Channels SHALL be fully independent; simultaneous presses on several channels produce simultaneous pulses.
REQ-019: A glitch shorter than PULSE_CNT_MAX consecutive high sample ticks SHALL produce no level and no pulse.

Reset
REQ-020: While rst_n=0: synchronizer flops, sample counter, saturating counters, pulse and toggle registers SHALL be 0; level, pulse, toggle read 0.
REQ-021: Reset assertion mid-count SHALL clear all state immediately; after release, the first sample_tick occurs SAMPLE_CNT_MAX cycles later.
REQ-022: A button held through reset release SHALL be treated as a new press (one pulse once saturated).

Configuration
REQ-023: Macro BUTTON_TOGGLE_EN defined: toggle[i] SHALL invert on every cycle pulse[i] is high.
REQ-024: Macro BUTTON_TOGGLE_EN undefined: toggle register SHALL not be built; toggle ties to all zeros.

Structure
REQ-025: Package button_pkg SHALL hold default constants SAMPLE_CNT_MAX_DEFAULT=62500 and PULSE_CNT_MAX_DEFAULT=200.
REQ-026: The 2-flop synchronizer SHALL be a sub-module named synchronizer, parameterised by WIDTH, instanced once.
REQ-027: Sample counter, saturating counters and edge detect SHALL live in button_conditioner.

Verification (bench uses WIDTH=4, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3)
REQ-028: Reset then buttons=0 for 100 cycles -> level, pulse, toggle all 0 throughout.
REQ-029: buttons[0] 0->1 and held 40 cycles -> level[0] rises within 2+4*3+1=15 cycles, pulse[0] high exactly 1 cycle, toggle[0]=1 (with BUTTON_TOGGLE_EN); other bits stay 0.
REQ-030: buttons[1] high 6 cycles then low -> no level[1], no pulse[1]; saturating counter back to 0.
REQ-031: Press and release buttons[2] twice, 40 cycles each phase -> exactly 2 pulses, toggle[2] ends at 0; without BUTTON_TOGGLE_EN toggle stays 0.
REQ-032: buttons=4'b1111 simultaneously -> all four pulse bits high on the same cycle.
REQ-033: rst_n pulsed low while buttons[3] high and counter at 2 -> all outputs 0 at once; after release one new pulse[3] within 15 cycles.
